rain_monitor: RTL and testbench

Multi-channel successor to the single-input rain alarm in the smart home automation design. It watches `N_CH` rain sensor inputs and gives each one input synchronisation, a debounce filter, and a drying hold time. Each channel can optionally latch its alarm until software acknowledges it. The block drives a combined alarm, per-channel alarm bits, an active-channel count and a new-alarm pulse to the home controller.

---
 rtl/rain_pkg.sv | 19 +
 rtl/rain_channel.sv | 115 +++++++++++
 rtl/rain_monitor.sv | 58 +++++
 tb/tb_rain_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rain_pkg.sv
// rtl/rain_pkg.sv - state encoding and counter sizing shared by rain_monitor and rain_channel
package rain_pkg;

  typedef enum logic [1:0] {
    ST_DRY    = 2'b00,
    ST_WET    = 2'b01,
    ST_DRYING = 2'b10
  } rain_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter width serves both debounce and hold; the compare values bound it, so it never wraps.
  function automatic int cnt_width(input int deb, input int hold);
    return $clog2(max_int(deb, hold) + 1);
  endfunction

endpackage

// File: rtl/rain_channel.sv
// rtl/rain_channel.sv - one sensor channel: synchroniser, debounce/hold FSM, optional alarm latch (RAIN_LATCH_EN)
module rain_channel
  import rain_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  input  logic enable,
  input  logic ack,
  output logic alarm,
  output logic enter_wet
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  rain_state_t   state;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] hold_cnt;

  // Two-flop synchroniser; it keeps running while the channel is disabled so re-enabling sees a settled level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sensor};
    end
  end

  assign s = sync_q[1];

  // Flags the edge on which this channel moves DRY->WET; the top registers it into new_alarm.
  always_comb begin
    enter_wet = 1'b0;
    if (!rst && enable && (state == ST_DRY) && s && (deb_cnt == DEB_LAST)) begin
      enter_wet = 1'b1;
    end
  end

`ifndef RAIN_LATCH_EN
  logic unused_ack;
  assign unused_ack = ack;
`endif

  // Debounce/hold FSM with registered alarm; reset beats disable, disable beats normal update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_DRY;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      alarm    <= 1'b0;
    end else if (!enable) begin
      state    <= ST_DRY;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      alarm    <= 1'b0;
    end else begin
      case (state)
        ST_DRY: begin
          if (!s) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= ST_WET;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + CW'(1);
          end
        end
        ST_WET: begin
          if (!s) begin
            state    <= ST_DRYING;
            hold_cnt <= '0;
          end
        end
        ST_DRYING: begin
          if (s) begin
            state    <= ST_WET;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ST_DRY;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_DRY;
          deb_cnt  <= '0;
          hold_cnt <= '0;
        end
      endcase

`ifdef RAIN_LATCH_EN
      // Latched alarm: set on entry to WET (wins over ack), cleared only by ack while DRY.
      if (enter_wet) begin
        alarm <= 1'b1;
      end else if ((state == ST_DRY) && ack) begin
        alarm <= 1'b0;
      end
`else
      // Follow the next state: high whenever the FSM will be in WET or DRYING.
      alarm <= enter_wet
             || (state == ST_WET)
             || ((state == ST_DRYING) && (s || (hold_cnt != HOLD_LAST)));
`endif
    end
  end

endmodule

// File: rtl/rain_monitor.sv
// rtl/rain_monitor.sv - multi-channel rain alarm top; alarm latching selected by RAIN_LATCH_EN
module rain_monitor
  import rain_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            rain_sensor,
  input  logic [N_CH-1:0]            ch_enable,
  input  logic [N_CH-1:0]            ack,
  output logic [N_CH-1:0]            alarm_ch,
  output logic                       rain_alarm,
  output logic [$clog2(N_CH+1)-1:0]  active_count,
  output logic                       new_alarm
);

  localparam int AW = $clog2(N_CH + 1);

  logic [N_CH-1:0] enter_wet;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rain_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sensor    (rain_sensor[i]),
      .enable    (ch_enable[i]),
      .ack       (ack[i]),
      .alarm     (alarm_ch[i]),
      .enter_wet (enter_wet[i])
    );
  end

  assign rain_alarm = |alarm_ch;

  // Population count of the registered per-channel alarms.
  always_comb begin
    active_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      active_count = active_count + AW'(alarm_ch[i]);
    end
  end

  // Single pulse per edge, however many channels entered WET together.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_alarm <= 1'b0;
    end else begin
      new_alarm <= |enter_wet;
    end
  end

endmodule

// File: tb/tb_rain_monitor.sv
// tb/tb_rain_monitor.sv - scoreboard bench for rain_monitor (latch expectations follow RAIN_LATCH_EN)
module tb_rain_monitor;

`ifdef RAIN_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rain_sensor;
  logic [3:0] ch_enable;
  logic [3:0] ack;
  logic [3:0] alarm_ch;
  logic       rain_alarm;
  logic [2:0] active_count;
  logic       new_alarm;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] alarm;
    logic [2:0] cnt;
    logic       nw;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  rain_monitor #(
    .N_CH            (4),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rain_sensor  (rain_sensor),
    .ch_enable    (ch_enable),
    .ack          (ack),
    .alarm_ch     (alarm_ch),
    .rain_alarm   (rain_alarm),
    .active_count (active_count),
    .new_alarm    (new_alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue an expectation dly cycles from now, kept sorted by cycle.
  task automatic expect_at(input int dly, input string tag, input logic [3:0] a, input logic [2:0] n, input logic nw);
    exp_t x;
    int idx;
    x.cyc = cyc + dly;
    x.tag = $sformatf("%s@+%0d", tag, dly);
    x.alarm = a;
    x.cnt = n;
    x.nw = nw;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > x.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, x);
  endtask

  task automatic expect_range(input int d0, input int d1, input string tag, input logic [3:0] a, input logic [2:0] n, input logic nw);
    for (int d = d0; d <= d1; d++) expect_at(d, tag, a, n, nw);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs against due expectations on the falling edge.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_eq({e.tag, ".alarm_ch"}, 32'(alarm_ch), 32'(e.alarm));
      check_eq({e.tag, ".active_count"}, 32'(active_count), 32'(e.cnt));
      check_eq({e.tag, ".new_alarm"}, 32'(new_alarm), 32'(e.nw));
      check_eq({e.tag, ".rain_alarm"}, 32'(rain_alarm), 32'(|e.alarm));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1;
    rain_sensor = 4'b1111;
    ch_enable = 4'b1111;
    ack = 4'b0000;
    step(3);
    expect_at(0, "reset", 4'b0000, 3'd0, 1'b0);

    // 1: ch0 wet after release
    rst = 1'b0;
    rain_sensor = 4'b0001;
    expect_at(5, "rise_early", 4'b0000, 3'd0, 1'b0);
    expect_at(6, "rise", 4'b0001, 3'd1, 1'b1);
    expect_at(7, "rise_after", 4'b0001, 3'd1, 1'b0);
    step(7);

    // 2: ch1 3-sample glitch
    rain_sensor = 4'b0011;
    expect_range(1, 10, "glitch", 4'b0001, 3'd1, 1'b0);
    step(3);
    rain_sensor = 4'b0001;
    step(7);

    // 3a: ch0 dries
    rain_sensor = 4'b0000;
    expect_at(10, "hold_last", 4'b0001, 3'd1, 1'b0);
    expect_at(11, "hold_end", LATCH ? 4'b0001 : 4'b0000, LATCH ? 3'd1 : 3'd0, 1'b0);
    step(11);
    rain_sensor = 4'b0001;
    expect_at(5, "rewet_early", LATCH ? 4'b0001 : 4'b0000, LATCH ? 3'd1 : 3'd0, 1'b0);
    expect_at(6, "rewet", 4'b0001, 3'd1, 1'b1);
    expect_at(7, "rewet_after", 4'b0001, 3'd1, 1'b0);
    step(10);

    // 3b: short re-wet during DRYING keeps alarm high, hold restarts
    rain_sensor = 4'b0000;
    expect_range(1, 16, "drying_rewet", 4'b0001, 3'd1, 1'b0);
    expect_at(17, "drying_end", LATCH ? 4'b0001 : 4'b0000, LATCH ? 3'd1 : 3'd0, 1'b0);
    step(4);
    rain_sensor = 4'b0001;
    step(2);
    rain_sensor = 4'b0000;
    step(11);
    ack = 4'b0001;
    expect_at(0, "ack0_pre", LATCH ? 4'b0001 : 4'b0000, LATCH ? 3'd1 : 3'd0, 1'b0);
    expect_at(1, "ack0_post", 4'b0000, 3'd0, 1'b0);
    step(1);
    ack = 4'b0000;

    // 4: ch2 latch behaviour
    rain_sensor = 4'b0100;
    expect_at(5, "ch2_early", 4'b0000, 3'd0, 1'b0);
    expect_at(6, "ch2_rise", 4'b0100, 3'd1, 1'b1);
    expect_at(7, "ch2_after", 4'b0100, 3'd1, 1'b0);
    step(8);
    rain_sensor = 4'b0000;
    expect_range(1, 10, "ch2_drying_ack", 4'b0100, 3'd1, 1'b0);
    expect_at(11, "ch2_dry", LATCH ? 4'b0100 : 4'b0000, LATCH ? 3'd1 : 3'd0, 1'b0);
    step(4);
    ack = 4'b0100;
    step(1);
    ack = 4'b0000;
    step(8);
    ack = 4'b0100;
    expect_at(0, "ch2_ack_pre", LATCH ? 4'b0100 : 4'b0000, LATCH ? 3'd1 : 3'd0, 1'b0);
    expect_at(1, "ch2_ack_post", 4'b0000, 3'd0, 1'b0);
    step(1);
    ack = 4'b0000;
    step(1);

    // 5: ch0+ch3 together, then disable ch3
    rain_sensor = 4'b1001;
    expect_at(5, "pair_early", 4'b0000, 3'd0, 1'b0);
    expect_at(6, "pair_rise", 4'b1001, 3'd2, 1'b1);
    expect_at(7, "pair_after", 4'b1001, 3'd2, 1'b0);
    step(8);
    ch_enable = 4'b0111;
    expect_at(0, "dis_pre", 4'b1001, 3'd2, 1'b0);
    expect_range(1, 8, "dis", 4'b0001, 3'd1, 1'b0);
    step(8);
    ch_enable = 4'b1111;
    expect_at(3, "reen_early", 4'b0001, 3'd1, 1'b0);
    expect_at(4, "reen_rise", 4'b1001, 3'd2, 1'b1);
    expect_at(5, "reen_after", 4'b1001, 3'd2, 1'b0);
    step(6);

    // 6: one-cycle reset mid-operation
    rst = 1'b1;
    expect_at(0, "rst_pre", 4'b1001, 3'd2, 1'b0);
    expect_at(1, "rst_post", 4'b0000, 3'd0, 1'b0);
    step(1);
    rst = 1'b0;
    expect_at(5, "post_rst_early", 4'b0000, 3'd0, 1'b0);
    expect_at(6, "post_rst_rise", 4'b1001, 3'd2, 1'b1);
    expect_at(7, "post_rst_after", 4'b1001, 3'd2, 1'b0);
    step(8);

    rain_sensor = 4'b0000;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      step(1);
      guard++;
    end
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
